// File: rtl/ask_pkg.sv
// ---------------------------------------------------------------------------
// ask_pkg
// Definitions shared by the ASK transmitter and the matching receiver.
//   ask_state_t            : transmitter frame state
//   ASK_SYNCWORD           : syncword, sent MSB first
//   ASK_PREAMBLE           : preamble as it appears at sample rate (4 samples
//                            per symbol, alternating starting with 1)
//   ASK_SAMPLES_PER_SYMBOL : default clk cycles per symbol
//   even_parity()          : XOR of a payload byte
//   ask_max()              : integer maximum, used for counter sizing
// ---------------------------------------------------------------------------
package ask_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SYNC     = 3'd2,
        DATA     = 3'd3,
        PARITY   = 3'd4,
        GAP      = 3'd5
    } ask_state_t;

    localparam logic [7:0]  ASK_SYNCWORD           = 8'b11100101;
    localparam logic [31:0] ASK_PREAMBLE           = 32'hF0F0F0F0;
    localparam int          ASK_SAMPLES_PER_SYMBOL = 4;
    localparam int          ASK_PREAMBLE_SYMBOLS   = 8;
    localparam int          ASK_SYNCWORD_WIDTH     = 8;
    localparam int          ASK_GAP_SYMBOLS        = 4;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    function automatic int ask_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ask_symbol_timer.sv
// ---------------------------------------------------------------------------
// ask_symbol_timer
// Sample counter 0..SAMPLES_PER_SYMBOL-1 that produces a one-cycle symbol
// strobe on the last sample of every symbol while run is high.
//   clk        : sample clock
//   reset      : synchronous, active-high
//   run        : count enable; the counter is held at 0 while run is low
//   sym_strobe : high in the final sample cycle of each symbol
// ---------------------------------------------------------------------------
module ask_symbol_timer
    import ask_pkg::*;
#(
    parameter int SAMPLES_PER_SYMBOL = ASK_SAMPLES_PER_SYMBOL
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic sym_strobe
);

    localparam int                CNT_W    = $clog2(SAMPLES_PER_SYMBOL) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLES_PER_SYMBOL - 1);

    logic [CNT_W-1:0] cnt_r;

    // Sample counter: cleared while idle, wraps at the last sample of a symbol.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!run) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign sym_strobe = run && (cnt_r == CNT_LAST);

endmodule

// File: rtl/ask_tx.sv
// ---------------------------------------------------------------------------
// ask_tx
// ASK (on-off keyed) baseband transmitter. Bytes accepted on a valid/ready
// handshake are framed as preamble, syncword, payload (MSB first) and an
// idle gap, and emitted on serialout at SAMPLES_PER_SYMBOL samples/symbol.
// Consecutive bytes offered at the end of a payload byte extend the frame
// without a gap.
//
// Optional build macro: ASK_TX_PARITY_EN -- adds one even-parity symbol after
// every payload byte; the continuation handshake then moves to the last
// sample of the parity symbol.
//
// Ports:
//   clk       : sample clock
//   reset     : synchronous, active-high
//   tx_data   : payload byte
//   tx_valid  : tx_data is valid
//   tx_ready  : a byte transfers on an edge with tx_valid && tx_ready
//   serialout : OOK bitstream, 1 = carrier on (flop output)
//   busy      : high whenever a frame is in progress
// ---------------------------------------------------------------------------
module ask_tx
    import ask_pkg::*;
#(
    parameter int                        SAMPLES_PER_SYMBOL = ASK_SAMPLES_PER_SYMBOL,
    parameter int                        PREAMBLE_SYMBOLS   = ASK_PREAMBLE_SYMBOLS,
    parameter int                        SYNCWORD_WIDTH     = ASK_SYNCWORD_WIDTH,
    parameter logic [SYNCWORD_WIDTH-1:0] SYNCWORD           = ASK_SYNCWORD,
    parameter int                        GAP_SYMBOLS        = ASK_GAP_SYMBOLS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serialout,
    output logic       busy
);

    // One symbol-index counter serves every state, so size it for the longest.
    localparam int IDX_MAX = ask_max(ask_max(PREAMBLE_SYMBOLS, SYNCWORD_WIDTH),
                                     ask_max(8, GAP_SYMBOLS));
    localparam int IDX_W   = $clog2(IDX_MAX) + 1;

    localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_SYMBOLS - 1);
    localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(SYNCWORD_WIDTH - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(7);
    localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(GAP_SYMBOLS - 1);

    ask_state_t          state_r;
    ask_state_t          state_nxt_s;
    logic [IDX_W-1:0]    idx_r;
    logic [IDX_W-1:0]    idx_nxt_s;
    logic [7:0]          shreg_r;
    logic [7:0]          shreg_nxt_s;
    logic                serial_nxt_s;
    logic                sym_strobe_s;
    logic                transfer_s;
    logic [SYNCWORD_WIDTH-1:0] sync_sel_s;
    logic [7:0]          data_sel_s;

    ask_symbol_timer #(
        .SAMPLES_PER_SYMBOL (SAMPLES_PER_SYMBOL)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (state_r != IDLE),
        .sym_strobe (sym_strobe_s)
    );

    // Handshake decode from registered state only: ready while idle, and in
    // the last sample of the final symbol of a byte (bit 0, or parity).
    always_comb begin
        tx_ready = 1'b0;
        if (state_r == IDLE) begin
            tx_ready = 1'b1;
`ifdef ASK_TX_PARITY_EN
        end else if ((state_r == PARITY) && sym_strobe_s) begin
            tx_ready = 1'b1;
`else
        end else if ((state_r == DATA) && sym_strobe_s && (idx_r == DATA_LAST)) begin
            tx_ready = 1'b1;
`endif
        end else begin
            tx_ready = 1'b0;
        end
    end

    assign transfer_s = tx_valid && tx_ready;
    assign busy       = (state_r != IDLE);

    // Frame sequencing: next state, symbol index and payload register.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        shreg_nxt_s = shreg_r;
        case (state_r)
            IDLE: begin
                idx_nxt_s = {IDX_W{1'b0}};
                if (transfer_s) begin
                    shreg_nxt_s = tx_data;
                    state_nxt_s = PREAMBLE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PREAMBLE: begin
                if (sym_strobe_s) begin
                    if (idx_r == PRE_LAST) begin
                        state_nxt_s = SYNC;
                        idx_nxt_s   = {IDX_W{1'b0}};
                    end else begin
                        idx_nxt_s   = idx_r + IDX_W'(1);
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            SYNC: begin
                if (sym_strobe_s) begin
                    if (idx_r == SYNC_LAST) begin
                        state_nxt_s = DATA;
                        idx_nxt_s   = {IDX_W{1'b0}};
                    end else begin
                        idx_nxt_s   = idx_r + IDX_W'(1);
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            DATA: begin
                if (sym_strobe_s) begin
                    if (idx_r == DATA_LAST) begin
                        idx_nxt_s = {IDX_W{1'b0}};
`ifdef ASK_TX_PARITY_EN
                        state_nxt_s = PARITY;
`else
                        if (transfer_s) begin
                            shreg_nxt_s = tx_data;
                            state_nxt_s = DATA;
                        end else begin
                            state_nxt_s = GAP;
                        end
`endif
                    end else begin
                        idx_nxt_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
`ifdef ASK_TX_PARITY_EN
            PARITY: begin
                if (sym_strobe_s) begin
                    idx_nxt_s = {IDX_W{1'b0}};
                    if (transfer_s) begin
                        shreg_nxt_s = tx_data;
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = GAP;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
`endif
            GAP: begin
                if (sym_strobe_s) begin
                    if (idx_r == GAP_LAST) begin
                        state_nxt_s = IDLE;
                        idx_nxt_s   = {IDX_W{1'b0}};
                    end else begin
                        idx_nxt_s   = idx_r + IDX_W'(1);
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = {IDX_W{1'b0}};
                shreg_nxt_s = 8'h00;
            end
        endcase
    end

    // Symbol value for the upcoming cycle, derived from the next state so the
    // first preamble sample appears right after the accepting edge.
    always_comb begin
        sync_sel_s   = SYNCWORD >> (SYNC_LAST - idx_nxt_s);
        data_sel_s   = shreg_nxt_s >> (DATA_LAST - idx_nxt_s);
        serial_nxt_s = 1'b0;
        case (state_nxt_s)
            PREAMBLE: serial_nxt_s = ~idx_nxt_s[0];
            SYNC:     serial_nxt_s = sync_sel_s[0];
            DATA:     serial_nxt_s = data_sel_s[0];
`ifdef ASK_TX_PARITY_EN
            PARITY:   serial_nxt_s = even_parity(shreg_nxt_s);
`endif
            default:  serial_nxt_s = 1'b0;
        endcase
    end

    // State, index, payload and serial output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            idx_r     <= {IDX_W{1'b0}};
            shreg_r   <= 8'h00;
            serialout <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            shreg_r   <= shreg_nxt_s;
            serialout <= serial_nxt_s;
        end
    end

endmodule

// File: tb/tb_ask_tx.sv
// ---------------------------------------------------------------------------
// tb_ask_tx
// Directed bench for ask_tx. Captures serialout / tx_ready / busy sample by
// sample and compares them, 32 samples at a time, against a symbol-level
// frame model built here. Honours ASK_TX_PARITY_EN in the model.
// ---------------------------------------------------------------------------
module tb_ask_tx;
    import ask_pkg::*;

    localparam int SPS = 4;
`ifdef ASK_TX_PARITY_EN
    localparam int BYTE_SYMS = 9;
`else
    localparam int BYTE_SYMS = 8;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       serialout;
    logic       busy;

    int checks;
    int failures;

    logic ser_a  [256];
    logic rdy_a  [256];
    logic busy_a [256];
    logic exp_sym[64];
    int   exp_len;
    int   exp_nbytes;

    ask_tx dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .serialout (serialout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Symbol-level model of a frame of nb bytes (b0 then b1).
    task automatic build_exp(input int nb, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] sw;
        logic [7:0] b;
        int n;
        sw = ASK_SYNCWORD;
        n = 0;
        for (int i = 0; i < 64; i++) exp_sym[i] = 1'b0;
        for (int i = 0; i < 8; i++) begin exp_sym[n] = (i % 2 == 0); n++; end
        for (int i = 7; i >= 0; i--) begin exp_sym[n] = sw[i]; n++; end
        for (int j = 0; j < nb; j++) begin
            b = (j == 0) ? b0 : b1;
            for (int i = 7; i >= 0; i--) begin exp_sym[n] = b[i]; n++; end
`ifdef ASK_TX_PARITY_EN
            exp_sym[n] = ^b; n++;
`endif
        end
        exp_len    = n + 4;
        exp_nbytes = nb;
    endtask

    function automatic logic exp_ser(input int s);
        return (s / SPS < exp_len) ? exp_sym[s / SPS] : 1'b0;
    endfunction

    function automatic logic exp_rdy(input int s);
        logic r;
        r = (s >= exp_len * SPS);
        for (int m = 0; m < exp_nbytes; m++)
            if (s == (16 + BYTE_SYMS * (m + 1)) * SPS - 1) r = 1'b1;
        return r;
    endfunction

    // Send a frame starting from idle and capture n samples.
    // mode 0: single byte; 1: b0 then b1 with tx_valid held; 2: single byte
    // with stray tx_valid pulses in preamble and gap.
    task automatic run_frame(input string tag, input int mode,
                             input logic [7:0] b0, input logic [7:0] b1, input int n);
        logic [31:0] g_ser, g_rdy, g_busy, e_ser, e_rdy, e_busy;
        tx_data  = b0;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int k = 1; k <= n; k++) begin
            ser_a[k-1]  = serialout;
            rdy_a[k-1]  = tx_ready;
            busy_a[k-1] = busy;
            case (mode)
                1: begin tx_data = b1;    tx_valid = (k <= 96 + 4 * (BYTE_SYMS - 8)); end
                2: begin tx_data = 8'hFF; tx_valid = (k == 4) || (k == 100) || (k == 112); end
                default: tx_valid = 1'b0;
            endcase
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        build_exp((mode == 1) ? 2 : 1, b0, b1);
        for (int c = 0; c < n / 32; c++) begin
            for (int j = 0; j < 32; j++) begin
                g_ser[31-j]  = ser_a[c*32+j];
                g_rdy[31-j]  = rdy_a[c*32+j];
                g_busy[31-j] = busy_a[c*32+j];
                e_ser[31-j]  = exp_ser(c*32+j);
                e_rdy[31-j]  = exp_rdy(c*32+j);
                e_busy[31-j] = (c*32+j < exp_len * SPS);
            end
            check_val($sformatf("%s_ser%0d", tag, c),  g_ser,  e_ser);
            check_val($sformatf("%s_rdy%0d", tag, c),  g_rdy,  e_rdy);
            check_val($sformatf("%s_busy%0d", tag, c), g_busy, e_busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_serial", {31'd0, serialout}, 32'd0);
        check_val("rst_busy",   {31'd0, busy},      32'd0);
        check_val("rst_ready",  {31'd0, tx_ready},  32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        run_frame("a5",  0, 8'hA5, 8'h00, 128);
        run_frame("b2b", 1, 8'h3C, 8'hFF, 160);
        run_frame("pls", 2, 8'h96, 8'h00, 128);

        // Reset in the middle of a 5A frame (sample 50 is syncword bit 4 = 0).
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
        end
        check_val("mid_busy",   {31'd0, busy},      32'd1);
        check_val("mid_serial", {31'd0, serialout}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("mrst_serial", {31'd0, serialout}, 32'd0);
        check_val("mrst_ready",  {31'd0, tx_ready},  32'd1);
        check_val("mrst_busy",   {31'd0, busy},      32'd0);
        run_frame("post", 0, 8'h5A, 8'h00, 128);

`ifdef ASK_TX_PARITY_EN
        run_frame("par07", 0, 8'h07, 8'h00, 128);
        run_frame("par03", 0, 8'h03, 8'h00, 128);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ask_tx.md
Name: ask_tx

Overview:
- ASK baseband transmitter: the far end of the ask_rcv link.
- Converts a byte stream (valid/ready) into an on-off keyed serial bitstream at sample rate.
- Frame format is preamble, then syncword, then payload bytes MSB first, then an idle gap.
- The preamble and syncword match what symbol_syncroniser correlates against. Serial output feeds the modulator/RF enable.

Parameters:
- SAMPLES_PER_SYMBOL, 4, clk cycles per symbol (equals 2*SYMBCLK_PRESCALER on the receive side); minimum 2.
- PREAMBLE_SYMBOLS, 8, number of alternating preamble symbols, starting with 1. Default gives 32'hF0F0F0F0 at sample rate.
- SYNCWORD_WIDTH, 8, syncword length in symbols.
- SYNCWORD, 8'b11100101, syncword, sent MSB first.
- GAP_SYMBOLS, 4, minimum zero symbols after each frame before the next may start.

Ports:
- clk, in, 1, sample clock; single clock domain.
- reset, in, 1, synchronous, active-high.
- tx_data, in, 8, payload byte.
- tx_valid, in, 1, tx_data is valid.
- tx_ready, out, 1, block accepts tx_data this cycle.
- serialout, out, 1, OOK bitstream (1 = carrier on).
- busy, out, 1, high whenever state is not IDLE.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Everything is registered on posedge clk.
- Reset: state=IDLE, serialout=0, busy=0, tx_ready=1 in the first cycle after reset. All counters and the shift register clear.
- Transfer rule: a byte transfers on a clk edge where tx_valid && tx_ready. tx_data is latched into an 8-bit shift register.
- Sample counter: 0..SAMPLES_PER_SYMBOL-1. Each symbol is held on serialout for exactly SAMPLES_PER_SYMBOL cycles.
- A symbol strobe fires when the counter equals SAMPLES_PER_SYMBOL-1. All state and bit advances occur on the strobe.
- IDLE: serialout=0, tx_ready=1, counters held at 0. On transfer, go to PREAMBLE. The first preamble sample appears on serialout in the next cycle (latency 1).
- PREAMBLE: symbol k (k=0..PREAMBLE_SYMBOLS-1) = ~k[0], i.e. 1,0,1,0...; tx_ready=0.
- SYNC: SYNCWORD bits MSB first, SYNCWORD_WIDTH symbols; tx_ready=0.
- DATA: shift register MSB first, 8 symbols.
  - tx_ready=1 only in the final sample cycle of bit 0.
  - If a transfer occurs then, the new byte loads and DATA restarts with no gap, so frames can carry any number of bytes.
  - Otherwise go to GAP.
- GAP: serialout=0 for GAP_SYMBOLS symbols, tx_ready=0, then IDLE.
- Frame length: total symbols = PREAMBLE_SYMBOLS + SYNCWORD_WIDTH + 8*N + GAP_SYMBOLS.
- tx_valid while tx_ready=0 is ignored. tx_data may change freely except on the transfer edge.
- Reset mid-frame: serialout=0 and state=IDLE at the next edge. The in-flight byte is dropped; no partial gap is emitted.
- Counter widths: $clog2 of each count bound plus 1 bit; no wrap beyond each terminal count.
- serialout is a direct flop output (glitch-free, no combinational path from inputs).

Optional Feature:
- Macro: ASK_TX_PARITY_EN.
- Defined: state PARITY follows each DATA byte and emits one even-parity symbol (XOR of the 8 data bits).
  - tx_ready moves to the final sample cycle of the PARITY symbol; continuation and GAP decisions happen there.
  - Per-byte cost is 9 symbols.
- Undefined: PARITY state and logic are absent; behaviour is exactly as above.

Decomposition:
- Package ask_pkg holds:
  - State enum: IDLE, PREAMBLE, SYNC, DATA, PARITY, GAP.
  - Default constants ASK_SYNCWORD=8'b11100101, ASK_PREAMBLE=32'hF0F0F0F0, ASK_SAMPLES_PER_SYMBOL=4.
  - The receiver shares these constants.
- One sub-module, ask_symbol_timer:
  - Parameter SAMPLES_PER_SYMBOL.
  - Inputs clk, reset, run; output sym_strobe.
  - Counter clears whenever run=0.
- The FSM and shift register stay in ask_tx.

Test Plan:
- Reset, then a single byte 8'hA5 with tx_valid held 1 cycle → serialout reproduces the expected stream, in samples:
  - 32'hF0F0F0F0 preamble.
  - 11100101 syncword, each bit x4 samples.
  - 10100101 payload, each bit x4 samples.
  - 16 zeros.
  - tx_ready high at sample 96 after acceptance, low during the gap, high again 16 cycles later; busy high for exactly 112 cycles.
- Back-to-back 8'h3C, 8'hFF with tx_valid held high → second byte accepted on the last sample of the first byte's bit 0; 64 contiguous data samples with no gap; single preamble/sync.
- tx_valid pulsed during PREAMBLE and GAP → no transfer; output is bit-identical to an idle-input frame.
- Reset asserted at sample 50 of the 8'h5A frame → serialout=0 and tx_ready=1 the next cycle; a new frame then starts cleanly with a full preamble.
- Loopback into ask_rcv/symbol_syncroniser:
  - preamble_sync fires at the end of the preamble.
  - syncwrd_lock sets after the syncword.
  - syncclk toggles thereafter.
- With ASK_TX_PARITY_EN defined, byte 8'h07 → parity symbol 1 after bit 0; byte 8'h03 → parity 0; frame lengthens by 4 samples per byte.
